// File: rtl/cf_seq_pkg.sv
// Shared constants and state encoding for the CompactFlash cycle sequencer.
// Holds the bus widths, the default timing values and the FSM state type.
package cf_seq_pkg;

    localparam int CF_ADDR_W = 11;
    localparam int CF_DATA_W = 8;

    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_HOLD_CYC    = 2;
    localparam int DEF_RESET_CYC   = 200;
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_CRST   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_WAITX  = 3'd4,
        ST_HOLD   = 3'd5,
        ST_FIN    = 3'd6
    } cf_state_t;

    // States in which CE#, REG#, address and write data are driven to the card.
    function automatic logic is_active(cf_state_t s);
        return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_WAITX) || (s == ST_HOLD);
    endfunction

    function automatic logic is_strobe(cf_state_t s);
        return (s == ST_STROBE) || (s == ST_WAITX);
    endfunction

endpackage

// File: rtl/cf_wait_sync.sv
// Two-flop synchroniser for the card's asynchronous WAIT# line.
// Resets to 1 (card not requesting wait).
module cf_wait_sync (
    input  logic clk,
    input  logic reset,
    input  logic wait_b_async,
    output logic wait_b_sync
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta        <= 1'b1;
            wait_b_sync <= 1'b1;
        end else begin
            meta        <= wait_b_async;
            wait_b_sync <= meta;
        end
    end

endmodule

// File: rtl/cf_cycle_sequencer.sv
// CompactFlash 8-bit access sequencer: card reset, CE#/REG#/OE#/WE# timing and WAIT# handling.
// Define CF_WAIT_TIMEOUT_EN to abort WAIT#-extended strobes after TIMEOUT_CYC cycles (err=1).
module cf_cycle_sequencer
    import cf_seq_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int RESET_CYC   = DEF_RESET_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 req_we,
    input  logic                 req_reg,
    input  logic [CF_ADDR_W-1:0] req_addr,
    input  logic [CF_DATA_W-1:0] req_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CF_DATA_W-1:0] rdata,
    output logic                 cf_reset,
    output logic                 cf_ce_b,
    output logic                 cf_reg_b,
    output logic                 cf_oe_b,
    output logic                 cf_we_b,
    output logic [CF_ADDR_W-1:0] cf_addr,
    output logic [CF_DATA_W-1:0] cf_dout,
    output logic                 cf_dout_en,
    input  logic [CF_DATA_W-1:0] cf_din,
    input  logic                 cf_wait_b
);

    // Handshake: req is sampled only while busy=0 (IDLE); there is no queue and no
    // back-pressure, a req seen while busy is dropped. done pulses for one cycle, err
    // is qualified by done, and rdata stays valid until the next accepted req.

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RESET_LD   = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);

    cf_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 crst_n;
    logic                 wait_s;

    logic                 we_q, reg_q;
    logic [CF_ADDR_W-1:0] addr_q;
    logic [CF_DATA_W-1:0] wdata_q;
    logic                 we_l, reg_l;
    logic [CF_ADDR_W-1:0] addr_l;
    logic [CF_DATA_W-1:0] wdata_l;
    logic                 act_n, stb_n, accept;

    cf_wait_sync u_wait_sync (
        .clk         (clk),
        .reset       (reset),
        .wait_b_async(cf_wait_b),
        .wait_b_sync (wait_s)
    );

    // In IDLE the pin registers must load from the live request, not the stale latch.
    assign accept  = (state == ST_IDLE) && req;
    assign we_l    = (state == ST_IDLE) ? req_we    : we_q;
    assign reg_l   = (state == ST_IDLE) ? req_reg   : reg_q;
    assign addr_l  = (state == ST_IDLE) ? req_addr  : addr_q;
    assign wdata_l = (state == ST_IDLE) ? req_wdata : wdata_q;

`ifdef CF_WAIT_TIMEOUT_EN
    logic tmo_n;
    logic err_q;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        crst_n  = 1'b0;
`ifdef CF_WAIT_TIMEOUT_EN
        tmo_n   = 1'b0;
`endif
        case (state)
            ST_CRST: begin
                // cf_reset drops one cycle before IDLE so busy trails the card reset.
                crst_n = cf_reset && (cnt != '0);
                if (!cf_reset) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (req) begin
                    state_n = ST_SETUP;
                    cnt_n   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_n = ST_STROBE;
                    cnt_n   = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    if (!wait_s) begin
                        state_n = ST_WAITX;
                        cnt_n   = TIMEOUT_LD;
                    end else begin
                        state_n = ST_HOLD;
                        cnt_n   = HOLD_LD;
                    end
                end
            end
            ST_WAITX: begin
                if (wait_s) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LD;
                end
`ifdef CF_WAIT_TIMEOUT_EN
                else if (cnt == '0) begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LD;
                    tmo_n   = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (cnt == '0) state_n = ST_FIN;
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_CRST;
        endcase
    end

    assign act_n = is_active(state_n);
    assign stb_n = is_strobe(state_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_CRST;
            cnt        <= RESET_LD;
            cf_reset   <= 1'b1;
            cf_ce_b    <= 1'b1;
            cf_reg_b   <= 1'b1;
            cf_oe_b    <= 1'b1;
            cf_we_b    <= 1'b1;
            cf_addr    <= '0;
            cf_dout    <= '0;
            cf_dout_en <= 1'b0;
            rdata      <= '0;
            we_q       <= 1'b0;
            reg_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cf_reset   <= crst_n;
            cf_ce_b    <= !act_n;
            cf_reg_b   <= !(act_n && reg_l);
            cf_oe_b    <= !(stb_n && !we_l);
            cf_we_b    <= !(stb_n && we_l);
            cf_addr    <= act_n ? addr_l : '0;
            cf_dout    <= (act_n && we_l) ? wdata_l : '0;
            cf_dout_en <= act_n && we_l;
            if (accept) begin
                we_q    <= req_we;
                reg_q   <= req_reg;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Read data is taken on the same edge that raises OE#.
            if (is_strobe(state) && (state_n == ST_HOLD) && !we_q) begin
`ifdef CF_WAIT_TIMEOUT_EN
                rdata <= tmo_n ? 8'hFF : cf_din;
`else
                rdata <= cf_din;
`endif
            end
        end
    end

`ifdef CF_WAIT_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       err_q <= 1'b0;
        else if (accept) err_q <= 1'b0;
        else if (tmo_n)  err_q <= 1'b1;
    end
    assign err = (state == ST_FIN) && err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

endmodule
